// File: rtl/clk_div_pkg.sv
// clk_div_pkg - shared defaults and helpers for the programmable clock divider.
// Optional phase feature is controlled by the CLK_DIV_PHASE_EN macro (see top).
// Helper functions work on a fixed 32-bit width; callers cast to CNT_W.

package clk_div_pkg;

    // Default geometry and reset configuration
    localparam int CNT_W_DEF    = 8;
    localparam int NUM_CH_DEF   = 2;
    localparam int DEF_DIV_DEF  = 5;
    localparam int DEF_HIGH_DEF = 1;

    // Working width of the helper functions
    localparam int FN_W = 32;

    // Smallest divide ratio that still produces a toggling output
    localparam logic [FN_W-1:0] MIN_DIV = 32'd2;

    // Ratios 0 and 1 cannot form a period with a high and a low phase,
    // so they are promoted to 2.
    function automatic logic [FN_W-1:0] clamp_div(input logic [FN_W-1:0] div);
        logic [FN_W-1:0] res;
        if (div < MIN_DIV) begin
            res = MIN_DIV;
        end else begin
            res = div;
        end
        return res;
    endfunction

    // Bring a phase offset into the range [0, div). The caller always passes
    // an already clamped ratio, the zero guard only keeps the function total.
    function automatic logic [FN_W-1:0] phase_wrap(input logic [FN_W-1:0] phase,
                                                  input logic [FN_W-1:0] div);
        logic [FN_W-1:0] res;
        if (div == 32'd0) begin
            res = 32'd0;
        end else begin
            res = phase % div;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan - one duty-cycle output of the programmable divider.
// Compares the shared period count (shifted by this channel's phase) against
// the channel's high-count and registers the result, so the output is a
// plain flop and cannot glitch. With CLK_DIV_PHASE_EN undefined the top ties
// phase_i to zero.

module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] phase_i,
    output logic             clk_out_o
);

    logic [CNT_W-1:0] pc_s;
    logic             out_d;
    logic             out_q;

    // Phase-shifted count modulo the period, then the high/low decision
    always_comb begin
        pc_s  = {CNT_W{1'b0}};
        out_d = 1'b0;
        if (cnt_i < phase_i) begin
            // cnt + div - phase is below div, so modular CNT_W arithmetic is exact
            pc_s = cnt_i + div_i - phase_i;
        end else begin
            pc_s = cnt_i - phase_i;
        end
        if (en_i) begin
            out_d = (pc_s < high_i);
        end else begin
            out_d = 1'b0;
        end
    end

    // Output flop, cleared asynchronously
    always_ff @(posedge clk_i or negedge clr_i) begin
        if (!clr_i) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign clk_out_o = out_q;

endmodule

// File: rtl/clk_divider_prog.sv
// clk_divider_prog - run-time programmable integer clock divider with NUM_CH
// duty-cycle outputs sharing one period counter.
// New configuration is staged in pending registers and applied at the period
// wrap (or immediately while disabled) so no partial period is ever emitted.
// Optional feature: define CLK_DIV_PHASE_EN to add a per-channel phase offset
// input cfg_phase; otherwise every channel runs with phase 0.

module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int DEF_DIV  = DEF_DIV_DEF,
    parameter int DEF_HIGH = DEF_HIGH_DEF
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        cfg_div,
    input  logic [NUM_CH*CNT_W-1:0] cfg_high,
`ifdef CLK_DIV_PHASE_EN
    input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
`endif
    output logic                    cfg_busy,
    output logic                    tick,
    output logic [NUM_CH-1:0]       clk_out
);

    localparam int               CH_W     = NUM_CH * CNT_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Reset ratio goes through the same clamp as a captured one
    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(clamp_div(FN_W'(DEF_DIV)));
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);
    localparam logic [CH_W-1:0]  RST_HIGH_ALL = {NUM_CH{RST_HIGH}};

    // Period counter
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Active configuration
    logic [CNT_W-1:0] div_act_q;
    logic [CNT_W-1:0] div_act_d;
    logic [CH_W-1:0]  high_act_q;
    logic [CH_W-1:0]  high_act_d;

    // Staged configuration
    logic [CNT_W-1:0] pend_div_q;
    logic [CNT_W-1:0] pend_div_d;
    logic [CH_W-1:0]  pend_high_q;
    logic [CH_W-1:0]  pend_high_d;
    logic             pending_q;
    logic             pending_d;

    // Period-start pulse
    logic             tick_q;
    logic             tick_d;

    // Control terms
    logic [CNT_W-1:0] div_last_s;
    logic             wrap_s;
    logic             apply_s;
    logic [CNT_W-1:0] cap_div_s;
    logic [CH_W-1:0]  phase_act_s;

    // div_act is always >= 2, so the last count never underflows. Using >=
    // lets the counter recover from any out-of-range value in one cycle.
    assign div_last_s = div_act_q - CNT_ONE;
    assign wrap_s     = (cnt_q >= div_last_s);
    assign apply_s    = pending_q & (~en | wrap_s);
    assign cap_div_s  = CNT_W'(clamp_div(FN_W'(cfg_div)));

    // Next count: free-running modulo div_act while enabled, parked at 0 otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (wrap_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // Staging and application of div/high; a load coinciding with an apply
    // re-arms pending with the new values while the old ones go active.
    always_comb begin
        div_act_d   = div_act_q;
        high_act_d  = high_act_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        pending_d   = pending_q;
        if (apply_s) begin
            div_act_d  = pend_div_q;
            high_act_d = pend_high_q;
            pending_d  = 1'b0;
        end else begin
            pending_d  = pending_q;
        end
        if (cfg_load) begin
            pend_div_d  = cap_div_s;
            pend_high_d = cfg_high;
            pending_d   = 1'b1;
        end else begin
            pend_div_d  = pend_div_q;
            pend_high_d = pend_high_q;
        end
    end

    // Period-start pulse from the current count
    always_comb begin
        tick_d = 1'b0;
        if (en) begin
            tick_d = (cnt_q == CNT_ZERO);
        end else begin
            tick_d = 1'b0;
        end
    end

    // Counter, configuration and tick registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q       <= CNT_ZERO;
            div_act_q   <= RST_DIV;
            high_act_q  <= RST_HIGH_ALL;
            pend_div_q  <= RST_DIV;
            pend_high_q <= RST_HIGH_ALL;
            pending_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_act_q   <= div_act_d;
            high_act_q  <= high_act_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            pending_q   <= pending_d;
            tick_q      <= tick_d;
        end
    end

`ifdef CLK_DIV_PHASE_EN
    logic [CH_W-1:0] phase_act_q;
    logic [CH_W-1:0] phase_act_d;
    logic [CH_W-1:0] pend_phase_q;
    logic [CH_W-1:0] pend_phase_d;
    logic [CH_W-1:0] cap_phase_s;

    // Reduce each captured phase modulo the ratio captured alongside it
    always_comb begin
        cap_phase_s = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cap_phase_s[i*CNT_W +: CNT_W] =
                CNT_W'(phase_wrap(FN_W'(cfg_phase[i*CNT_W +: CNT_W]), FN_W'(cap_div_s)));
        end
    end

    // Phase staging follows exactly the same load/apply timing as high
    always_comb begin
        phase_act_d  = phase_act_q;
        pend_phase_d = pend_phase_q;
        if (apply_s) begin
            phase_act_d = pend_phase_q;
        end else begin
            phase_act_d = phase_act_q;
        end
        if (cfg_load) begin
            pend_phase_d = cap_phase_s;
        end else begin
            pend_phase_d = pend_phase_q;
        end
    end

    // Phase registers, zero after reset
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            phase_act_q  <= {CH_W{1'b0}};
            pend_phase_q <= {CH_W{1'b0}};
        end else begin
            phase_act_q  <= phase_act_d;
            pend_phase_q <= pend_phase_d;
        end
    end

    assign phase_act_s = phase_act_q;
`else
    assign phase_act_s = {CH_W{1'b0}};
`endif

    // One compare-and-register slice per output channel
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i     (clk),
            .clr_i     (clr),
            .en_i      (en),
            .cnt_i     (cnt_q),
            .div_i     (div_act_q),
            .high_i    (high_act_q[g*CNT_W +: CNT_W]),
            .phase_i   (phase_act_s[g*CNT_W +: CNT_W]),
            .clk_out_o (clk_out[g])
        );
    end

    assign cfg_busy = pending_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog - directed self-checking bench for clk_divider_prog.
// A small reference model of the counter/config behaviour predicts tick,
// clk_out and cfg_busy every cycle; per-window tick/high counts are also
// compared against hand-computed totals. Phase steps run when
// CLK_DIV_PHASE_EN is defined.

module tb_clk_divider_prog;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic        cfg_load;
    logic [7:0]  cfg_div;
    logic [15:0] cfg_high;
    logic [15:0] cfg_phase;
    logic        cfg_busy;
    logic        tick;
    logic [1:0]  clk_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] ec;
    logic [7:0] cur_div, cur_h0, cur_h1, cur_p0, cur_p1;
    logic [7:0] pd_div, pd_h0, pd_h1, pd_p0, pd_p1;
    logic       pflag;
    int         n_tick, n_hi0, n_hi1;

    clk_divider_prog #(
        .CNT_W    (8),
        .NUM_CH   (2),
        .DEF_DIV  (5),
        .DEF_HIGH (1)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .cfg_load (cfg_load),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
`ifdef CLK_DIV_PHASE_EN
        .cfg_phase(cfg_phase),
`endif
        .cfg_busy (cfg_busy),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pcv(input logic [7:0] c, input logic [7:0] p, input logic [7:0] d);
        return (c >= p) ? (c - p) : (c + d - p);
    endfunction

    task automatic model_reset();
        ec = 8'd0;
        cur_div = 8'd5; cur_h0 = 8'd1; cur_h1 = 8'd1; cur_p0 = 8'd0; cur_p1 = 8'd0;
        pd_div  = 8'd5; pd_h0  = 8'd1; pd_h1  = 8'd1; pd_p0  = 8'd0; pd_p1  = 8'd0;
        pflag = 1'b0;
    endtask

    task automatic clear_counts();
        n_tick = 0; n_hi0 = 0; n_hi1 = 0;
    endtask

    // One clock edge: predict outputs from the pre-edge state, check, advance model
    task automatic do_edge();
        logic [7:0] old;
        logic       exp_tick;
        logic [1:0] exp_out;
        logic       wrap;
        old = ec;
        exp_tick   = en && (old == 8'd0);
        exp_out[0] = en && (pcv(old, cur_p0, cur_div) < cur_h0);
        exp_out[1] = en && (pcv(old, cur_p1, cur_div) < cur_h1);
        @(posedge clk);
        #1;
        chk("tick", 32'(tick), 32'(exp_tick));
        chk("clk_out", 32'(clk_out), 32'(exp_out));
        if (tick === 1'b1) n_tick++;
        if (clk_out[0] === 1'b1) n_hi0++;
        if (clk_out[1] === 1'b1) n_hi1++;
        wrap = (old == cur_div - 8'd1);
        if (en) ec = wrap ? 8'd0 : old + 8'd1;
        else    ec = 8'd0;
        if (pflag && (!en || wrap)) begin
            cur_div = pd_div; cur_h0 = pd_h0; cur_h1 = pd_h1; cur_p0 = pd_p0; cur_p1 = pd_p1;
            pflag = 1'b0;
        end
        if (cfg_load) begin
            pd_div = (cfg_div < 8'd2) ? 8'd2 : cfg_div;
            pd_h0  = cfg_high[7:0];
            pd_h1  = cfg_high[15:8];
`ifdef CLK_DIV_PHASE_EN
            pd_p0  = cfg_phase[7:0] % pd_div;
            pd_p1  = cfg_phase[15:8] % pd_div;
`else
            pd_p0  = 8'd0;
            pd_p1  = 8'd0;
`endif
            pflag  = 1'b1;
        end
        chk("cfg_busy", 32'(cfg_busy), 32'(pflag));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_edge();
    endtask

    task automatic load(input logic [7:0] d, input logic [7:0] h0, input logic [7:0] h1,
                        input logic [7:0] p0, input logic [7:0] p1);
        cfg_div   = d;
        cfg_high  = {h1, h0};
        cfg_phase = {p1, p0};
        cfg_load  = 1'b1;
        do_edge();
        cfg_load  = 1'b0;
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 300 && pflag; i++) do_edge();
    endtask

    task automatic run_to_cnt(input logic [7:0] c);
        for (int i = 0; i < 300 && ec != c; i++) do_edge();
    endtask

    initial begin
        clr = 1'b0; en = 1'b1; cfg_load = 1'b0;
        cfg_div = 8'd0; cfg_high = 16'd0; cfg_phase = 16'd0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        // Defaults: div 5, both channels 1 of 5
        clear_counts();
        run(10);
        chk("def_ticks", 32'(n_tick), 32'd2);
        chk("def_hi0", 32'(n_hi0), 32'd2);
        chk("def_hi1", 32'(n_hi1), 32'd2);

        // Rate/duty change loaded mid-period: ch1 40%, ch0 20%
        run(2);
        load(8'd5, 8'd1, 8'd2, 8'd0, 8'd0);
        run_until_idle();
        clear_counts();
        run(10);
        chk("duty_ticks", 32'(n_tick), 32'd2);
        chk("duty_hi0", 32'(n_hi0), 32'd2);
        chk("duty_hi1", 32'(n_hi1), 32'd4);

        // div=1 clamps to 2
        load(8'd1, 8'd1, 8'd1, 8'd0, 8'd0);
        run_until_idle();
        clear_counts();
        run(8);
        chk("clamp_ticks", 32'(n_tick), 32'd4);
        chk("clamp_hi0", 32'(n_hi0), 32'd4);

        // high 0 -> constant low, high > div -> constant high
        load(8'd8, 8'd0, 8'd9, 8'd0, 8'd0);
        run_until_idle();
        clear_counts();
        run(16);
        chk("bound_ticks", 32'(n_tick), 32'd2);
        chk("bound_hi0", 32'(n_hi0), 32'd0);
        chk("bound_hi1", 32'(n_hi1), 32'd16);

        // Two loads inside one long period: last one wins
        load(8'd200, 8'd1, 8'd1, 8'd0, 8'd0);
        run_until_idle();
        run(5);
        load(8'd6, 8'd1, 8'd1, 8'd0, 8'd0);
        run(3);
        load(8'd10, 8'd1, 8'd1, 8'd0, 8'd0);
        run_until_idle();
        clear_counts();
        run(20);
        chk("dbl_ticks", 32'(n_tick), 32'd2);
        chk("dbl_hi0", 32'(n_hi0), 32'd2);

        // Enable dropped at cnt=3 of div 7 / high 4
        load(8'd7, 8'd4, 8'd4, 8'd0, 8'd0);
        run_until_idle();
        run_to_cnt(8'd3);
        en = 1'b0;
        do_edge();
        chk("en_drop_out", 32'(clk_out), 32'd0);
        run(2);
        en = 1'b1;
        do_edge();
        chk("en_rise_tick", 32'(tick), 32'd1);
        chk("en_rise_out", 32'(clk_out), 32'd3);
        run(6);

        // Asynchronous clear mid-period with a config pending
        run_to_cnt(8'd2);
        load(8'd3, 8'd2, 8'd2, 8'd0, 8'd0);
        clr = 1'b0;
        #1;
        chk("clr_out", 32'(clk_out), 32'd0);
        chk("clr_tick", 32'(tick), 32'd0);
        chk("clr_busy", 32'(cfg_busy), 32'd0);
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        clear_counts();
        run(10);
        chk("clr_def_ticks", 32'(n_tick), 32'd2);
        chk("clr_def_hi0", 32'(n_hi0), 32'd2);
        chk("clr_def_hi1", 32'(n_hi1), 32'd2);

`ifdef CLK_DIV_PHASE_EN
        // div 4, high 2, ch1 phase 2: complementary outputs
        load(8'd4, 8'd2, 8'd2, 8'd0, 8'd2);
        run_until_idle();
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            do_edge();
            chk("phase_compl", 32'(clk_out[1]), 32'(~clk_out[0]));
        end
        chk("phase_hi1", 32'(n_hi1), 32'd4);
        // phase 5 with div 4 behaves as phase 1
        load(8'd4, 8'd2, 8'd2, 8'd0, 8'd5);
        run_until_idle();
        run(8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
